// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit modified Galois LFSR pattern generator/checker pair.
package lfsr_pkg;

  localparam int         LFSR_W            = 8;
  localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'b10101010;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} chk_state_t;

  // The all-zero term in the feedback makes the zero state part of the sequence.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] taps);
    logic       f;
    logic [7:0] n;
    f    = (~|s[6:0]) ^ s[7];
    n[0] = f;
    for (int k = 1; k < 8; k++) begin
      n[k] = s[k-1] ^ (taps[k] & f);
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_deser.sv
// LSB-first serial-to-parallel converter; also exposes the completing word
// combinationally so the checker can act on the same edge that registers it.
module lfsr_deser
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              done,
  output logic [LFSR_W-1:0] rx_word,
  output logic [LFSR_W-1:0] word,
  output logic              word_valid
);

  logic [LFSR_W-1:0] sh;
  logic [2:0]        bit_cnt;

  assign rx_word = {in_bit, sh[LFSR_W-1:1]};
  assign done    = in_valid && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        sh      <= rx_word;
        bit_cnt <= bit_cnt + 3'd1;
        if (done) begin
          word       <= rx_word;
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the serial LFSR test stream: acquires lock on
// consecutive matching words, then flags and counts deviations.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter logic [7:0] TAPS     = LFSR_TAPS_DEFAULT,
  parameter int         STEPS    = 1,
  parameter int         LOCK_CNT = 4,
  parameter int         MISS_CNT = 3,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear,
  output logic [7:0]       word,
  output logic             word_valid,
  output logic             match,
  output logic             err,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_CNT + 1);

  chk_state_t        state, state_n;
  logic [7:0]        exp, exp_n;
  logic [HIT_W-1:0]  hit, hit_n, hit_inc;
  logic [MISS_W-1:0] miss, miss_n, miss_inc;
  logic              match_n, err_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              done;
  logic [7:0]        rx_word;

  function automatic logic [7:0] adv(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int i = 0; i < STEPS; i++) begin
      t = lfsr_step(t, TAPS);
    end
    return t;
  endfunction

  lfsr_deser u_deser (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .done       (done),
    .rx_word    (rx_word),
    .word       (word),
    .word_valid (word_valid)
  );

  assign hit_inc  = hit + 1'b1;
  assign miss_inc = miss + 1'b1;
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      exp       <= '0;
      hit       <= '0;
      miss      <= '0;
      match     <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      exp       <= exp_n;
      hit       <= hit_n;
      miss      <= miss_n;
      match     <= match_n;
      err       <= err_n;
      err_count <= cnt_n;
    end
  end

  // While locked the expected word free-runs, so isolated errors do not cost resync.
  always_comb begin
    state_n = state;
    exp_n   = exp;
    hit_n   = hit;
    miss_n  = miss;
    match_n = 1'b0;
    err_n   = 1'b0;
    cnt_n   = err_count;
    if (done) begin
      unique case (state)
        SEARCH: begin
          exp_n   = adv(rx_word);
          hit_n   = '0;
          state_n = TRACK;
        end
        TRACK: begin
          if (rx_word == exp) begin
            match_n = 1'b1;
            exp_n   = adv(exp);
            hit_n   = hit_inc;
            if (hit_inc == HIT_W'(LOCK_CNT)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            exp_n = adv(rx_word);
            hit_n = '0;
          end
        end
        LOCKED: begin
          exp_n = adv(exp);
          if (rx_word == exp) begin
            match_n = 1'b1;
            miss_n  = '0;
          end else begin
            err_n  = 1'b1;
            cnt_n  = (&err_count) ? err_count : err_count + 1'b1;
            miss_n = miss_inc;
            if (miss_inc == MISS_W'(MISS_CNT)) begin
              exp_n   = adv(rx_word);
              hit_n   = '0;
              state_n = TRACK;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    if (clear) begin
      cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: two instances share the stimulus, one with a
// 4-bit error counter so saturation can be reached quickly.
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        in_bit;
  logic        in_valid;
  logic        clear;
  logic [7:0]  word_a;
  logic        word_valid_a, match_a, err_a, locked_a;
  logic [15:0] err_count_a;
  logic [7:0]  word_b;
  logic        word_valid_b, match_b, err_b, locked_b;
  logic [3:0]  err_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_checker #(.TAPS(8'b10101010), .STEPS(1), .LOCK_CNT(2), .MISS_CNT(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clear(clear),
    .word(word_a), .word_valid(word_valid_a), .match(match_a), .err(err_a),
    .locked(locked_a), .err_count(err_count_a)
  );

  lfsr_checker #(.TAPS(8'b10101010), .STEPS(1), .LOCK_CNT(2), .MISS_CNT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clear(clear),
    .word(word_b), .word_valid(word_valid_b), .match(match_b), .err(err_b),
    .locked(locked_b), .err_count(err_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent formulation of the generator step, used only to extend long runs.
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    logic fb;
    fb = (s[6:0] == 7'd0) ? ~s[7] : s[7];
    return {s[6:0], fb} ^ (fb ? 8'hAA : 8'h00);
  endfunction

  function automatic logic [15:0] sat15(input int k);
    return (k > 15) ? 16'd15 : 16'(k);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkWord(input string tag, input logic [7:0] ew, input logic em,
                           input logic ee, input logic el, input logic [15:0] eca,
                           input logic [15:0] ecb);
    checkOutput({tag, ".word"},       16'(word_a),       16'(ew));
    checkOutput({tag, ".word_valid"}, 16'(word_valid_a), 16'd1);
    checkOutput({tag, ".match"},      16'(match_a),      16'(em));
    checkOutput({tag, ".err"},        16'(err_a),        16'(ee));
    checkOutput({tag, ".locked"},     16'(locked_a),     16'(el));
    checkOutput({tag, ".cnt_a"},      err_count_a,       eca);
    checkOutput({tag, ".cnt_b"},      16'(err_count_b),  ecb);
  endtask

  // Sends one word LSB-first; returns just after the edge that completes it.
  task automatic applyStimulus(input logic [7:0] w, input bit gaps, input bit clr_last);
    int g;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = w[i];
      clear    = (i == 7) ? clr_last : 1'b0;
      if (gaps && i != 7) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_bit   = ~in_bit;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic applyBits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = w[i];
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyReset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, ".word"},       16'(word_a),       16'd0);
    checkOutput({tag, ".word_valid"}, 16'(word_valid_a), 16'd0);
    checkOutput({tag, ".match"},      16'(match_a),      16'd0);
    checkOutput({tag, ".err"},        16'(err_a),        16'd0);
    checkOutput({tag, ".locked"},     16'(locked_a),     16'd0);
    checkOutput({tag, ".cnt_a"},      err_count_a,       16'd0);
    checkOutput({tag, ".cnt_b"},      16'(err_count_b),  16'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] model;
    int         k;
    rst      = 1'b1;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;

    applyReset("reset0");

    // Acquire lock with LOCK_CNT=2: 0x40 seeds, 0x80 and 0x00 match.
    applyStimulus(8'h40, 0, 0); checkWord("acq40", 8'h40, 0, 0, 0, 0, 0);
    applyStimulus(8'h80, 0, 0); checkWord("acq80", 8'h80, 1, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 0); checkWord("acq00", 8'h00, 1, 0, 1, 0, 0);
    applyStimulus(8'hAB, 0, 0); checkWord("acqAB", 8'hAB, 1, 0, 1, 0, 0);

    // Single error in place of 0xFD, then 0x51 resumes matching.
    applyStimulus(8'hFF, 0, 0); checkWord("err1",  8'hFF, 0, 1, 1, 1, 1);
    applyStimulus(8'h51, 0, 0); checkWord("err1ok", 8'h51, 1, 0, 1, 1, 1);
    @(posedge clk); #1;
    checkOutput("pulse.word_valid", 16'(word_valid_a), 16'd0);
    checkOutput("pulse.match",      16'(match_a),      16'd0);

    // Three misses (expected 0xA2, 0xEF, 0x75) drop lock; reseed from 0x00 gives 0xAB.
    applyStimulus(8'h00, 0, 0); checkWord("miss1", 8'h00, 0, 1, 1, 2, 2);
    applyStimulus(8'h00, 0, 0); checkWord("miss2", 8'h00, 0, 1, 1, 3, 3);
    applyStimulus(8'h00, 0, 0); checkWord("miss3", 8'h00, 0, 1, 0, 4, 4);
    applyStimulus(8'hAB, 0, 0); checkWord("relk1", 8'hAB, 1, 0, 0, 4, 4);
    applyStimulus(8'hFD, 0, 0); checkWord("relk2", 8'hFD, 1, 0, 1, 4, 4);
    applyStimulus(8'h51, 0, 0); checkWord("relk3", 8'h51, 1, 0, 1, 4, 4);

    // Same acquisition with idle cycles inside each word.
    applyReset("reset1");
    applyStimulus(8'h40, 1, 0); checkWord("gap40", 8'h40, 0, 0, 0, 0, 0);
    applyStimulus(8'h80, 1, 0); checkWord("gap80", 8'h80, 1, 0, 0, 0, 0);
    applyStimulus(8'h00, 1, 0); checkWord("gap00", 8'h00, 1, 0, 1, 0, 0);
    applyStimulus(8'hAB, 1, 0); checkWord("gapAB", 8'hAB, 1, 0, 1, 0, 0);
    applyStimulus(8'hFD, 1, 0); checkWord("gapFD", 8'hFD, 1, 0, 1, 0, 0);

    // Reset after 5 bits; the partial word must not leak into the next one.
    applyBits(8'hFF, 5);
    applyReset("reset_mid");
    applyStimulus(8'h40, 0, 0); checkWord("mid40", 8'h40, 0, 0, 0, 0, 0);
    applyStimulus(8'h80, 0, 0); checkWord("mid80", 8'h80, 1, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 0); checkWord("mid00", 8'h00, 1, 0, 1, 0, 0);

    // Two errors then one good word, repeated: stays locked, 4-bit count saturates.
    model = 8'hAB;
    k     = 0;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 2; j++) begin
        k++;
        applyStimulus(model ^ 8'h01, 0, 0);
        checkWord("sat_err", model ^ 8'h01, 0, 1, 1, 16'(k), sat15(k));
        model = ref_step(model);
      end
      applyStimulus(model, 0, 0);
      checkWord("sat_ok", model, 1, 0, 1, 16'(k), sat15(k));
      model = ref_step(model);
    end

    // Clear on the same edge as an error wins; clear also works with no valid bits.
    applyStimulus(model ^ 8'h01, 0, 1);
    checkWord("clr_err", model ^ 8'h01, 0, 1, 1, 0, 0);
    model = ref_step(model);
    applyStimulus(model, 0, 0);
    checkWord("clr_ok", model, 1, 0, 1, 0, 0);
    model = ref_step(model);
    applyStimulus(model ^ 8'h01, 0, 0);
    checkWord("clr_err2", model ^ 8'h01, 0, 1, 1, 1, 1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("clr_idle.cnt_a",  err_count_a,         16'd0);
    checkOutput("clr_idle.cnt_b",  16'(err_count_b),    16'd0);
    checkOutput("clr_idle.locked", 16'(locked_a),       16'd1);
    checkOutput("clr_idle.wvalid", 16'(word_valid_a),   16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial-in checker for the 8-bit LFSR pattern stream produced by the team's LFSR generator. Bits arrive LSB-first, qualified by `in_valid`. The block deserialises them into 8-bit words and self-synchronises a local copy of the same modified Galois LFSR to the received words. Once locked, it flags every word that deviates from the expected sequence. It sits at the receive end of the serial test link and feeds link BER/status monitoring.

## Interface
Parameters:
- `TAPS`, 8'b10101010, Galois tap mask; must match the generator.
- `STEPS`, 1, LFSR advances between consecutive transmitted words (range 1–8).
- `LOCK_CNT`, 4, consecutive matching words required to declare lock (≥1).
- `MISS_CNT`, 3, consecutive mismatching words while locked that drop lock (≥1).
- `CNT_W`, 16, width of the error counter.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `in_bit`, in, 1, serial data, LSB of each word first.
- `in_valid`, in, 1, `in_bit` is accepted on every clock where this is high.
- `clear`, in, 1, synchronous clear of `err_count` only.
- `word`, out, 8, last fully received word.
- `word_valid`, out, 1, one-cycle pulse when `word` updates.
- `match`, out, 1, one-cycle pulse with `word_valid` when `word` equals the expected word (states TRACK and LOCKED only).
- `err`, out, 1, one-cycle pulse with `word_valid` on a mismatch while LOCKED.
- `locked`, out, 1, high while in state LOCKED.
- `err_count`, out, CNT_W, saturating count of `err` pulses.

## Operation
- **LFSR step (shared with the generator):**
  - f = (~|s[6:0]) ^ s[7]
  - n[0] = f
  - n[k] = s[k-1] ^ (TAPS[k] & f) for k = 1..7
  - adv(s) = step applied STEPS times, unrolled combinationally.
  - Examples at STEPS=1: 0x40→0x80, 0x80→0x00, 0x00→0xAB, 0x01→0x02.
- **Deserialiser:**
  - On each cycle with `in_valid` high, shift `sh <= {in_bit, sh[7:1]}` and increment a 3-bit bit counter.
  - When the counter wraps from 7 to 0, the new value of `sh` is the word.
  - Cycles with `in_valid` low hold all deserialiser state.
- **State machine**, evaluated only on word completion:
  - **SEARCH:**
    - exp <= adv(word), hit count <= 0, go to TRACK.
    - `match` and `err` stay low.
  - **TRACK:**
    - If word == exp: `match`, exp <= adv(exp), hit count +1. When the hit count reaches LOCK_CNT, go to LOCKED with miss count 0.
    - Otherwise: reseed exp <= adv(word), hit count <= 0, no `err`.
  - **LOCKED:**
    - If word == exp: `match`, miss count <= 0.
    - Otherwise: `err`, `err_count` +1 (saturating at 2^CNT_W-1), miss count +1.
    - exp <= adv(exp) in both cases (flywheel).
    - When the miss count reaches MISS_CNT: reseed exp <= adv(word), hit count <= 0, go to TRACK.
- **Simultaneous `clear` and `err`:** clear wins, so `err_count` = 0; the `err` pulse is still asserted.
- **Reset values:**
  - `word`=0, `word_valid`=0, `match`=0, `err`=0, `locked`=0, `err_count`=0.
  - sh=0, bit counter=0, exp=0, hit/miss counts=0, state SEARCH.
- **Reset mid-word:** the partial word is discarded; the next 8 valid bits form a fresh word.

## Timing
- `word`, `word_valid`, `match`, `err`, `locked` and `err_count` are registered. They update on the clock edge that accepts the 8th valid bit, so they are visible in the cycle after that bit is presented.
- Bits may arrive back-to-back (one per cycle) indefinitely; no stall or backpressure.
- `locked` rises together with the `word_valid` of the LOCK_CNT-th match. It falls together with the `word_valid` of the MISS_CNT-th consecutive miss.
- `clear` takes effect at the next edge, independent of `in_valid`.

## Structure
- **Package `lfsr_pkg`:**
  - default TAPS constant
  - `lfsr_step(s, taps)` function, also to be used by the generator
  - state enum {SEARCH, TRACK, LOCKED}
- **Sub-module `lfsr_deser`:** the 8-bit shift register, bit counter, and `word`/`word_valid` output. The checker FSM instantiates it.

## Test plan
- **Acquire lock.** LOCK_CNT=2. Send words 0x40, 0x80, 0x00, 0xAB back-to-back. Required:
  - `match` pulses on 0x80, 0x00 and 0xAB.
  - `locked` rises with the 0x00 word.
  - `err_count` = 0.
- **Single error while locked.** After locking, send 0xFF in place of the expected 0xAB, then correct words. Required:
  - one `err` pulse, `err_count` = 1.
  - `locked` stays high.
  - `match` resumes on the next correct word.
- **Loss of lock.** MISS_CNT=3. While locked, send three consecutive wrong words. Required:
  - three `err` pulses.
  - `locked` falls with the third wrong word.
  - re-lock after LOCK_CNT further consecutive correct words following the new seed.
- **Gapped input.** Insert random `in_valid`-low cycles within words. Required: words and `match` results are identical to the back-to-back run.
- **Reset mid-word.** Assert `rst` after 5 bits. Required:
  - all outputs are 0 and the state is SEARCH.
  - the next 8 bits, LSB-first 0x40, give `word` = 0x40.
- **Counter saturation and clear.** CNT_W=4, forced errors. Required:
  - `err_count` sticks at 15.
  - `clear` coincident with an `err` yields 0.
